// File: rtl/uart_pkg.sv
// uart_pkg: constants and receiver state encoding shared by the UART transmitter and receiver
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10416;
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous pin that idles high
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver sampling each bit at its midpoint, with framing-error and break handling
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST = 3'(UART_DATA_BITS - 1);
    logic                      rxd_sync;
    rx_state_e                 state_q;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      busy_q;
    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rxd),
        .q_o   (rxd_sync)
    );
    // cnt is cleared on every state change; START waits half a bit so later samples land mid-bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_sync) begin
                        state_q <= RX_START;
                        busy_q  <= 1'b1;
                    end
                end
                RX_START: if (cnt_q == HALF) begin
                    cnt_q   <= '0;
                    state_q <= rxd_sync ? RX_IDLE : RX_DATA;
                    busy_q  <= !rxd_sync;
                    idx_q   <= '0;
                end
                RX_DATA: if (cnt_q == FULL) begin
                    cnt_q   <= '0;
                    shift_q <= {rxd_sync, shift_q[UART_DATA_BITS-1:1]};
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) state_q <= RX_STOP;
                end
                RX_STOP: if (cnt_q == FULL) begin
                    cnt_q   <= '0;
                    valid_q <= rxd_sync;
                    ferr_q  <= !rxd_sync;
                    busy_q  <= !rxd_sync;
                    state_q <= rxd_sync ? RX_IDLE : RX_BREAK;
                    if (rxd_sync) data_q <= shift_q;
                end
                RX_BREAK: begin
                    cnt_q <= '0;
                    if (rxd_sync) begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule
